// File: rtl/line_fill_responder.sv
// line_fill_responder: fetches 64-byte cache lines from main memory for the prog/data
// caches and drains the write-back FIFO into memory, write-backs first.
module line_fill_responder #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 16,
  parameter int INDEX_W    = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     is_req_f_prog,
  input  logic [20:0]              req_addr_f_prog,
  input  logic                     is_req_f_data,
  input  logic [20:0]              req_addr_f_data,
  input  logic                     fifo_empty,
  input  logic [31:0]              write_back_addr,
  input  logic [31:0]              write_back_data,
  output logic                     is_write_t_main,
  output logic [32*LINE_WORDS-1:0] read_main_prog_data,
  output logic [INDEX_W-1:0]       read_main_prog_addr,
  output logic                     is_write_prog_line,
  output logic [32*LINE_WORDS-1:0] read_main_data_data,
  output logic [INDEX_W-1:0]       read_main_data_addr,
  output logic                     is_write_data_line,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_ready,
  output logic                     busy
);
  localparam int BW = $clog2(LINE_WORDS);
  typedef enum logic [1:0] {IDLE, WB, FILL, DELIVER} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [20:0] line_q, line_d;
  logic chan_q, chan_d;
  logic [31:0] wb_addr_q, wb_addr_d, wb_data_q, wb_data_d;
  logic [32*LINE_WORDS-1:0] buf_q, buf_d;
  logic [INDEX_W-1:0] prog_idx_q, prog_idx_d, data_idx_q, data_idx_d;
  logic arm_prog_q, arm_prog_d, arm_data_q, arm_data_d;
  logic idle, take_data, take_prog, beat_hit, last, done, deliver;
  assign idle      = state_q == IDLE;
  assign take_data = idle && fifo_empty && arm_data_q && is_req_f_data;
  assign take_prog = idle && fifo_empty && !take_data && arm_prog_q && is_req_f_prog;
  assign beat_hit  = state_q == FILL && mem_ready;
  assign last      = beat_q == BW'(LINE_WORDS - 1);
  assign done      = beat_hit && last;
  assign deliver   = state_q == DELIVER;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      line_q     <= '0;
      chan_q     <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      buf_q      <= '0;
      prog_idx_q <= '0;
      data_idx_q <= '0;
      arm_prog_q <= 1'b1;
      arm_data_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      line_q     <= line_d;
      chan_q     <= chan_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      buf_q      <= buf_d;
      prog_idx_q <= prog_idx_d;
      data_idx_q <= data_idx_d;
      arm_prog_q <= arm_prog_d;
      arm_data_q <= arm_data_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !fifo_empty ? WB : (take_data || take_prog) ? FILL : IDLE;
      WB:      state_d = mem_ready ? IDLE : WB;
      FILL:    state_d = done ? DELIVER : FILL;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    wb_addr_d  = is_write_t_main ? write_back_addr : wb_addr_q;
    wb_data_d  = is_write_t_main ? write_back_data : wb_data_q;
    line_d     = take_data ? req_addr_f_data : take_prog ? req_addr_f_prog : line_q;
    chan_d     = take_data ? 1'b1 : take_prog ? 1'b0 : chan_q;
    beat_d     = beat_hit ? beat_q + 1'b1 : beat_q;
    buf_d      = buf_q;
    if (beat_hit) buf_d[32*beat_q +: 32] = mem_rdata;
    prog_idx_d = done && !chan_q ? line_q[INDEX_W-1:0] : prog_idx_q;
    data_idx_d = done && chan_q ? line_q[INDEX_W-1:0] : data_idx_q;
    // Re-arm only once the cache has dropped its request, so a held request is served once.
    arm_prog_d = !is_req_f_prog || (arm_prog_q && !(deliver && !chan_q));
    arm_data_d = !is_req_f_data || (arm_data_q && !(deliver && chan_q));
  end
  always_comb begin
    // Pop is gated by reset so no entry is lost while reset holds the FSM in IDLE.
    is_write_t_main     = idle && !fifo_empty && reset;
    mem_req             = state_q == WB || state_q == FILL;
    mem_we              = state_q == WB;
    mem_addr            = state_q == WB ? ADDR_W'(wb_addr_q) :
                          state_q == FILL ? ADDR_W'({line_q, beat_q, 2'b00}) : '0;
    mem_wdata           = state_q == WB ? wb_data_q : '0;
    is_write_prog_line  = deliver && !chan_q;
    is_write_data_line  = deliver && chan_q;
    read_main_prog_data = buf_q;
    read_main_data_data = buf_q;
    read_main_prog_addr = prog_idx_q;
    read_main_data_addr = data_idx_q;
    busy                = !idle;
  end
endmodule

// File: tb/tb_line_fill_responder.sv
// tb_line_fill_responder: directed checks of line fills, write-back priority, re-arm,
// memory stalls and mid-fill reset against hand-computed values.
module tb_line_fill_responder;
  logic clk = 0, reset = 0;
  logic is_req_f_prog = 0, is_req_f_data = 0;
  logic [20:0] req_addr_f_prog = 0, req_addr_f_data = 0;
  logic fifo_empty, is_write_t_main;
  logic [31:0] write_back_addr, write_back_data;
  logic [511:0] read_main_prog_data, read_main_data_data;
  logic [6:0] read_main_prog_addr, read_main_data_addr;
  logic is_write_prog_line, is_write_data_line;
  logic mem_req, mem_we, mem_ready = 0, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, rd_base = 0;
  logic [31:0] wbf_a [8], wbf_d [8];
  int wr_ptr = 0, rd_ptr = 0, stall_n = 0;
  int cyc = 0, rd_cnt = 0, wr_cnt = 0, pop_cnt = 0, prog_cnt = 0, data_cnt = 0;
  int prog_cyc = 0, data_cyc = 0, fill_cyc = 0, last_wr_cyc = 0, stab_err = 0;
  logic [31:0] rd_log [512], wr_a [16], wr_d [16];
  int checks = 0, errors = 0;
  int r0, w0, p0, d0, q0;
  always #5 clk = ~clk;
  assign fifo_empty      = rd_ptr == wr_ptr;
  assign write_back_addr = wbf_a[rd_ptr[2:0]];
  assign write_back_data = wbf_d[rd_ptr[2:0]];
  assign mem_rdata       = rd_base + 32'(mem_addr[5:2]);
  line_fill_responder dut (
    .clk(clk), .reset(reset),
    .is_req_f_prog(is_req_f_prog), .req_addr_f_prog(req_addr_f_prog),
    .is_req_f_data(is_req_f_data), .req_addr_f_data(req_addr_f_data),
    .fifo_empty(fifo_empty), .write_back_addr(write_back_addr), .write_back_data(write_back_data),
    .is_write_t_main(is_write_t_main),
    .read_main_prog_data(read_main_prog_data), .read_main_prog_addr(read_main_prog_addr),
    .is_write_prog_line(is_write_prog_line),
    .read_main_data_data(read_main_data_data), .read_main_data_addr(read_main_data_addr),
    .is_write_data_line(is_write_data_line),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );
  // Memory model, FIFO pop and event log, all sampled mid-cycle.
  always @(negedge clk) begin
    static logic pop_pend = 0, prev_wait = 0, prev_rd = 0;
    static logic [31:0] prev_addr = 0;
    static int stall_cnt = 0;
    if (pop_pend) rd_ptr = rd_ptr + 1;
    if (mem_req && stall_cnt < stall_n) begin
      mem_ready = 0;
      stall_cnt++;
    end else begin
      mem_ready = mem_req;
      stall_cnt = 0;
    end
    cyc++;
    if (mem_req && prev_wait && mem_addr != prev_addr) stab_err++;
    prev_wait = mem_req && !mem_ready;
    prev_addr = mem_addr;
    if (mem_req && !mem_we && !prev_rd) fill_cyc = cyc;
    prev_rd = mem_req && !mem_we;
    if (mem_req && mem_ready && !mem_we && rd_cnt < 512) begin
      rd_log[rd_cnt] = mem_addr;
      rd_cnt++;
    end
    if (mem_req && mem_ready && mem_we && wr_cnt < 16) begin
      wr_a[wr_cnt] = mem_addr;
      wr_d[wr_cnt] = mem_wdata;
      wr_cnt++;
      last_wr_cyc = cyc;
    end
    pop_pend = is_write_t_main;
    if (pop_pend) pop_cnt++;
    if (is_write_prog_line) begin prog_cnt++; prog_cyc = cyc; end
    if (is_write_data_line) begin data_cnt++; data_cyc = cyc; end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_buf", read_main_prog_data[63:0], 0);
    chk("rst_idx", read_main_data_addr, 0);
    chk("rst_strobes", {is_write_prog_line, is_write_data_line, is_write_t_main}, 0);
    reset = 1;
    step(2);
    // Prog fill, zero wait
    rd_base = 32'h1000; r0 = rd_cnt; p0 = prog_cnt;
    req_addr_f_prog = 21'h00085; is_req_f_prog = 1;
    for (int i = 0; i < 100 && prog_cnt == p0; i++) step();
    is_req_f_prog = 0;
    step(5);
    chk("p_cnt", prog_cnt - p0, 1);
    chk("p_reads", rd_cnt - r0, 16);
    chk("p_addr0", rd_log[r0], 32'h2140);
    chk("p_addr1", rd_log[r0+1], 32'h2144);
    chk("p_addr15", rd_log[r0+15], 32'h217C);
    chk("p_latency", prog_cyc - fill_cyc + 1, 17);
    chk("p_idx", read_main_prog_addr, 7'h05);
    chk("p_lo", read_main_prog_data[31:0], 32'h1000);
    chk("p_hi", read_main_prog_data[511:480], 32'h100F);
    // Write-back priority over a simultaneous data request
    rd_base = 32'h2000; w0 = wr_cnt; q0 = pop_cnt; d0 = data_cnt;
    wbf_a[0] = 32'h100; wbf_d[0] = 32'hAA; wbf_a[1] = 32'h104; wbf_d[1] = 32'hBB;
    wr_ptr = 2;
    req_addr_f_data = 21'h001A3; is_req_f_data = 1;
    for (int i = 0; i < 100 && data_cnt == d0; i++) step();
    is_req_f_data = 0;
    step(3);
    chk("wb_writes", wr_cnt - w0, 2);
    chk("wb_pops", pop_cnt - q0, 2);
    chk("wb_a0", wr_a[w0], 32'h100);
    chk("wb_d0", wr_d[w0], 32'hAA);
    chk("wb_a1", wr_a[w0+1], 32'h104);
    chk("wb_d1", wr_d[w0+1], 32'hBB);
    chk("wb_before_fill", fill_cyc > last_wr_cyc, 1);
    chk("wb_fill_cnt", data_cnt - d0, 1);
    chk("wb_fill_idx", read_main_data_addr, 7'h23);
    chk("wb_fill_w1", read_main_data_data[63:32], 32'h2001);
    // Dual request: data first
    rd_base = 32'h3000; p0 = prog_cnt; d0 = data_cnt;
    req_addr_f_data = 21'h00040; req_addr_f_prog = 21'h00011;
    is_req_f_data = 1; is_req_f_prog = 1;
    for (int i = 0; i < 200 && (prog_cnt == p0 || data_cnt == d0); i++) step();
    step(20);
    chk("dual_data_cnt", data_cnt - d0, 1);
    chk("dual_prog_cnt", prog_cnt - p0, 1);
    chk("dual_order", data_cyc < prog_cyc, 1);
    chk("dual_data_idx", read_main_data_addr, 7'h40);
    chk("dual_prog_idx", read_main_prog_addr, 7'h11);
    chk("dual_prog_w0", read_main_prog_data[31:0], 32'h3000);
    is_req_f_data = 0; is_req_f_prog = 0;
    step(2);
    // Held request is not re-served until it drops
    rd_base = 32'h4000; p0 = prog_cnt;
    req_addr_f_prog = 21'h00007; is_req_f_prog = 1;
    for (int i = 0; i < 100 && prog_cnt == p0; i++) step();
    r0 = rd_cnt;
    step(50);
    chk("held_cnt", prog_cnt - p0, 1);
    chk("held_no_reads", rd_cnt - r0, 0);
    is_req_f_prog = 0;
    step();
    is_req_f_prog = 1;
    for (int i = 0; i < 100 && prog_cnt - p0 < 2; i++) step();
    chk("rearm_cnt", prog_cnt - p0, 2);
    chk("rearm_addr", rd_log[r0], 32'h1C0);
    is_req_f_prog = 0;
    step(2);
    // Memory stalls, 3 wait cycles per beat
    stall_n = 3; rd_base = 32'h5000; p0 = prog_cnt; r0 = rd_cnt; stab_err = 0;
    req_addr_f_prog = 21'h12345; is_req_f_prog = 1;
    for (int i = 0; i < 200 && prog_cnt == p0; i++) step();
    is_req_f_prog = 0;
    step(2);
    stall_n = 0;
    chk("stall_cnt", prog_cnt - p0, 1);
    chk("stall_stable", stab_err, 0);
    chk("stall_latency", prog_cyc - fill_cyc + 1, 65);
    chk("stall_addr0", rd_log[r0], 32'h48D140);
    chk("stall_addr15", rd_log[r0+15], 32'h48D17C);
    chk("stall_idx", read_main_prog_addr, 7'h45);
    chk("stall_hi", read_main_prog_data[511:480], 32'h500F);
    // Reset in the middle of a fill
    rd_base = 32'h6000; d0 = data_cnt; r0 = rd_cnt;
    req_addr_f_data = 21'h0ABCD; is_req_f_data = 1;
    for (int i = 0; i < 100 && rd_cnt - r0 < 7; i++) step();
    chk("mid_beats", rd_cnt - r0, 7);
    reset = 0;
    step();
    chk("mid_req_drop", mem_req, 0);
    chk("mid_busy", busy, 0);
    step(3);
    chk("mid_no_strobe", data_cnt - d0, 0);
    r0 = rd_cnt;
    reset = 1;
    for (int i = 0; i < 100 && data_cnt == d0; i++) step();
    is_req_f_data = 0;
    step(2);
    chk("restart_cnt", data_cnt - d0, 1);
    chk("restart_reads", rd_cnt - r0, 16);
    chk("restart_addr0", rd_log[r0], 32'h2AF340);
    chk("restart_idx", read_main_data_addr, 7'h4D);
    chk("restart_w7", read_main_data_data[255:224], 32'h6007);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
